// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: lock/button inputs and reset/status outputs of the reset sequencer
interface rst_sequencer_if;
    logic       i_pll_locked;
    logic       i_btn_n;
    logic       o_rst;
    logic       o_rst_n;
    logic       o_run;
    logic [1:0] o_state;

    modport master (
        output i_pll_locked, i_btn_n,
        input  o_rst, o_rst_n, o_run, o_state
    );

    modport slave (
        input  i_pll_locked, i_btn_n,
        output o_rst, o_rst_n, o_run, o_state
    );
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases SoC reset after PLL lock and a debounced released button
// have both been stable for a full 2^POR_BITS-cycle hold window.
module rst_sequencer #(
    parameter int POR_BITS = 25,
    parameter int DB_BITS  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    rst_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        HOLD      = 2'b01,
        RUN       = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          lock_s_q, btn_s_q;
    logic                btn_db_q, btn_db_d;
    logic [DB_BITS-1:0]  db_cnt_q, db_cnt_d;
    logic [POR_BITS-1:0] por_cnt_q, por_cnt_d;
    logic                rst_q, rst_n_q, run_q, run_d;
    logic                db_diff, ok;

    // btn_db only follows btn_s after 2^DB_BITS consecutive differing cycles
    always_comb begin
        db_diff  = btn_s_q[1] != btn_db_q;
        db_cnt_d = (db_diff && !(&db_cnt_q)) ? db_cnt_q + DB_BITS'(1) : '0;
        btn_db_d = (db_diff && (&db_cnt_q)) ? btn_s_q[1] : btn_db_q;
    end

    always_comb begin
        ok        = lock_s_q[1] & btn_db_q;
        state_d   = state_q;
        por_cnt_d = '0;
        case (state_q)
            WAIT_LOCK: state_d = ok ? HOLD : WAIT_LOCK;
            HOLD: begin
                if (!ok)
                    state_d = WAIT_LOCK;
                else if (&por_cnt_q)
                    state_d = RUN;
                else
                    por_cnt_d = por_cnt_q + POR_BITS'(1);
            end
            RUN:     state_d = ok ? RUN : WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
        run_d = (state_d == RUN) && (state_q != RUN);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lock_s_q  <= 2'b00;
            btn_s_q   <= 2'b11;
            btn_db_q  <= 1'b1;
            db_cnt_q  <= '0;
            por_cnt_q <= '0;
            state_q   <= WAIT_LOCK;
            rst_q     <= 1'b1;
            rst_n_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            lock_s_q  <= {lock_s_q[0], bus.i_pll_locked};
            btn_s_q   <= {btn_s_q[0], bus.i_btn_n};
            btn_db_q  <= btn_db_d;
            db_cnt_q  <= db_cnt_d;
            por_cnt_q <= por_cnt_d;
            state_q   <= state_d;
            rst_q     <= state_d != RUN;
            rst_n_q   <= state_d == RUN;
            run_q     <= run_d;
        end
    end

    assign bus.o_rst   = rst_q;
    assign bus.o_rst_n = rst_n_q;
    assign bus.o_run   = run_q;
    assign bus.o_state = state_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed scenarios plus random stimulus against a streak-based model
module tb_rst_sequencer;
    localparam int POR_BITS = 3;
    localparam int DB_BITS  = 2;
    localparam int HOLD_LEN = 1 << POR_BITS;
    localparam int DB_LEN   = 1 << DB_BITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    rst_sequencer_if bus();

    rst_sequencer #(.POR_BITS(POR_BITS), .DB_BITS(DB_BITS)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: the FSM state is a pure function of how many consecutive edges
    // saw (synchronized lock && debounced button); reset zeroes everything.
    logic [1:0] m_ls = 2'b00;
    logic [1:0] m_bs = 2'b11;
    logic       m_db = 1'b1;
    int         m_run = 0;
    int         m_streak = 0;
    logic [4:0] exp_vec, obs;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ls     <= 2'b00;
            m_bs     <= 2'b11;
            m_db     <= 1'b1;
            m_run    <= 0;
            m_streak <= 0;
        end else begin
            m_ls <= {m_ls[0], bus.i_pll_locked};
            m_bs <= {m_bs[0], bus.i_btn_n};
            if (m_bs[1] == m_db)
                m_run <= 0;
            else if (m_run + 1 == DB_LEN) begin
                m_db  <= m_bs[1];
                m_run <= 0;
            end else
                m_run <= m_run + 1;
            m_streak <= (m_ls[1] && m_db) ? ((m_streak < 1000) ? m_streak + 1 : m_streak) : 0;
        end
    end

    always_comb begin
        exp_vec = {(m_streak == 0) ? 2'b00 : (m_streak <= HOLD_LEN) ? 2'b01 : 2'b10,
                   m_streak <= HOLD_LEN, m_streak > HOLD_LEN, m_streak == HOLD_LEN + 1};
        obs = {bus.o_state, bus.o_rst, bus.o_rst_n, bus.o_run};
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_pll_locked = 1'b0;
        bus.i_btn_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (obs !== 5'b00_1_0_0) begin
            mismatched++;
            $display("FAIL reset_state got %b want %b", obs, 5'b00_1_0_0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL reset_model t=%0t got %b want %b", $time, obs, exp_vec); end
        end
    endtask

    task automatic test_startup();
        bus.i_pll_locked = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            compared += 3;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL startup_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== (e < 10)) begin mismatched++; $display("FAIL startup_rst e=%0d got %b want %b", e, bus.o_rst, e < 10); end
            if (bus.o_run !== (e == 10)) begin mismatched++; $display("FAIL startup_run e=%0d got %b want %b", e, bus.o_run, e == 10); end
        end
        compared++;
        if (bus.o_state !== 2'b10) begin mismatched++; $display("FAIL startup_state got %b want 10", bus.o_state); end
    endtask

    task automatic test_lock_loss();
        bus.i_pll_locked = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            compared += 3;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL lockloss_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== (e >= 2)) begin mismatched++; $display("FAIL lockloss_rst e=%0d got %b want %b", e, bus.o_rst, e >= 2); end
            if (bus.o_run !== 1'b0) begin mismatched++; $display("FAIL lockloss_run e=%0d got %b want 0", e, bus.o_run); end
        end
        compared++;
        if (bus.o_state !== 2'b00) begin mismatched++; $display("FAIL lockloss_state got %b want 00", bus.o_state); end
    endtask

    task automatic test_lock_glitch();
        bus.i_pll_locked = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            compared += 2;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL glitch_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== 1'b1) begin mismatched++; $display("FAIL glitch_rst e=%0d got %b want 1", e, bus.o_rst); end
        end
        compared++;
        if (bus.o_state !== 2'b01) begin mismatched++; $display("FAIL glitch_hold got %b want 01", bus.o_state); end
        bus.i_pll_locked = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            compared += 2;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL glitch_drop_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== 1'b1) begin mismatched++; $display("FAIL glitch_drop_rst e=%0d got %b want 1", e, bus.o_rst); end
        end
        compared++;
        if (bus.o_state !== 2'b00) begin mismatched++; $display("FAIL glitch_wait got %b want 00", bus.o_state); end
        bus.i_pll_locked = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            compared += 3;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL glitch_reseq_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== (e < 10)) begin mismatched++; $display("FAIL glitch_reseq_rst e=%0d got %b want %b", e, bus.o_rst, e < 10); end
            if (bus.o_run !== (e == 10)) begin mismatched++; $display("FAIL glitch_reseq_run e=%0d got %b want %b", e, bus.o_run, e == 10); end
        end
    endtask

    task automatic test_btn_bounce();
        int runs;
        bus.i_btn_n = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_btn_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            compared += 2;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL bounce_short_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== 1'b0) begin mismatched++; $display("FAIL bounce_short_rst e=%0d got %b want 0", e, bus.o_rst); end
        end
        bus.i_btn_n = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            compared++;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL bounce_long_model e=%0d got %b want %b", e, obs, exp_vec); end
        end
        bus.i_btn_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({bus.o_state, bus.o_rst} !== 3'b00_1) begin
            mismatched++;
            $display("FAIL bounce_long_reset got %b want 001", {bus.o_state, bus.o_rst});
        end
        runs = 0;
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            runs += int'(bus.o_run === 1'b1);
            compared++;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL bounce_reseq_model e=%0d got %b want %b", e, obs, exp_vec); end
        end
        compared++;
        if (runs != 1 || bus.o_state !== 2'b10) begin
            mismatched++;
            $display("FAIL bounce_reseq got runs=%0d state=%b want runs=1 state=10", runs, bus.o_state);
        end
    endtask

    task automatic test_sync_reset();
        rst_n = 1'b0;
        @(negedge clk);
        compared += 2;
        if (obs !== 5'b00_1_0_0) begin mismatched++; $display("FAIL syncrst_state got %b want %b", obs, 5'b00_1_0_0); end
        if (obs !== exp_vec) begin mismatched++; $display("FAIL syncrst_model got %b want %b", obs, exp_vec); end
        rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            compared += 3;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL syncrst_reseq_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_rst !== (e < 10)) begin mismatched++; $display("FAIL syncrst_reseq_rst e=%0d got %b want %b", e, bus.o_rst, e < 10); end
            if (bus.o_run !== (e == 10)) begin mismatched++; $display("FAIL syncrst_reseq_run e=%0d got %b want %b", e, bus.o_run, e == 10); end
        end
    endtask

    task automatic test_simultaneous();
        bus.i_btn_n = 1'b0;
        repeat (4) @(negedge clk);
        bus.i_pll_locked = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            compared += 2;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL simul_model e=%0d got %b want %b", e, obs, exp_vec); end
            if (bus.o_state !== ((e < 2) ? 2'b10 : 2'b00)) begin
                mismatched++;
                $display("FAIL simul_state e=%0d got %b want %b", e, bus.o_state, (e < 2) ? 2'b10 : 2'b00);
            end
        end
        bus.i_pll_locked = 1'b1;
        bus.i_btn_n = 1'b1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            compared++;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL simul_reseq_model e=%0d got %b want %b", e, obs, exp_vec); end
        end
        compared++;
        if (bus.o_state !== 2'b10) begin mismatched++; $display("FAIL simul_reseq_state got %b want 10", bus.o_state); end
    endtask

    task automatic test_random();
        int press = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            compared++;
            if (obs !== exp_vec) begin mismatched++; $display("FAIL random_model c=%0d got %b want %b", c, obs, exp_vec); end
            if (bus.i_pll_locked ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 7) == 0))
                bus.i_pll_locked = ~bus.i_pll_locked;
            if (press == 0 && $urandom_range(0, 29) == 0)
                press = $urandom_range(1, 8);
            bus.i_btn_n = (press == 0);
            if (press > 0)
                press--;
            rst_n = ($urandom_range(0, 249) != 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_lock_loss();
        test_lock_glitch();
        test_btn_bounce();
        test_sync_reset();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
